// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: gates the 4004 core with a one-cycle clock enable (run/halt, single-step, prescaled run, PC breakpoint).
// Latency: a request or tick in cycle t gives cpu_ce in cycle t+1; no backpressure, and all outputs are registered.
module cpu_run_ctrl #(
    parameter int            CW    = 24,
    parameter logic [CW-1:0] DIV1  = 24'd5999999,
    parameter logic [CW-1:0] DIV10 = 24'd599999
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [1:0]  clk_sel,
    input  logic        step_req,
    input  logic        run_req,
    input  logic        bp_en,
    input  logic [11:0] bp_addr,
    input  logic [11:0] pc_addr,
    output logic        cpu_ce,
    output logic        halted,
    output logic        bp_hit,
    output logic [15:0] ce_count
);

    typedef enum logic {HALT = 1'b0, RUN = 1'b1} runState_t;

    runState_t     state, stateNext;
    logic [CW-1:0] prescCnt;
    logic [1:0]    selPrev;
    logic          exempt;
    logic          selChanged;
    logic          tick;
    logic          bpMatch;
    logic          bpStop;
    logic          startRun;
    logic          issue;

    assign selChanged = (clk_sel != selPrev);
    assign bpMatch    = bp_en && (pc_addr == bp_addr) && !exempt;
    assign bpStop     = (state == RUN) && tick && !selChanged && !run_req && bpMatch;
    assign halted     = (state == HALT);

    always_comb begin
        tick = 1'b0;
        if (state == RUN) begin
            case (clk_sel)
                2'b11:   tick = 1'b1;
                2'b01:   tick = (prescCnt == DIV1);
                2'b10:   tick = (prescCnt == DIV10);
                default: tick = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= HALT;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        if (state == HALT) begin
            if (run_req && (clk_sel != 2'b00)) begin
                stateNext = RUN;
            end
        end else begin
            if (run_req || (selChanged && (clk_sel == 2'b00)) || bpStop) begin
                stateNext = HALT;
            end
        end
    end

    // A speed change always swallows that cycle's enable so the new period starts clean.
    always_comb begin
        issue    = 1'b0;
        startRun = 1'b0;
        if (state == HALT) begin
            startRun = run_req && (clk_sel != 2'b00);
            issue    = step_req && !run_req && !selChanged;
        end else begin
            issue    = tick && !run_req && !selChanged && !bpMatch;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            prescCnt <= '0;
        end else if ((state == RUN) && (stateNext == RUN) && !selChanged && (^clk_sel)) begin
            prescCnt <= tick ? '0 : prescCnt + CW'(1);
        end else begin
            prescCnt <= '0;
        end
    end

    // exempt lets a resume execute the instruction the breakpoint stopped on.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            exempt <= 1'b0;
            bp_hit <= 1'b0;
        end else begin
            if (startRun) begin
                exempt <= 1'b1;
            end else if ((state == RUN) && issue) begin
                exempt <= 1'b0;
            end
            if (startRun) begin
                bp_hit <= 1'b0;
            end else if (bpStop) begin
                bp_hit <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            selPrev  <= 2'b00;
            cpu_ce   <= 1'b0;
            ce_count <= 16'h0000;
        end else begin
            selPrev <= clk_sel;
            cpu_ce  <= issue;
            if (cpu_ce) begin
                ce_count <= ce_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: stimulus pushes the cycle of every expected cpu_ce pulse, a negedge monitor pops and compares.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic [1:0]  clk_sel;
    logic        step_req;
    logic        run_req;
    logic        bp_en;
    logic [11:0] bp_addr;
    logic [11:0] pc_addr = 12'h000;
    logic        cpu_ce;
    logic        halted;
    logic        bp_hit;
    logic [15:0] ce_count;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   expQ[$];
    logic pcTrack = 1'b0;

    cpu_run_ctrl #(.CW(24), .DIV1(24'd9), .DIV10(24'd3)) dut (
        .clk(clk), .nrst(nrst), .clk_sel(clk_sel), .step_req(step_req),
        .run_req(run_req), .bp_en(bp_en), .bp_addr(bp_addr), .pc_addr(pc_addr),
        .cpu_ce(cpu_ce), .halted(halted), .bp_hit(bp_hit), .ce_count(ce_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: PC advances as soon as the core sees its enable.
    always @(posedge clk) begin
        #1;
        if (!pcTrack) pc_addr = 12'h000;
        else if (cpu_ce) pc_addr = pc_addr + 12'h001;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        int expCyc;
        if (cpu_ce === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ce: pulse at cycle %0d, expected none", cyc);
            end else begin
                expCyc = expQ.pop_front();
                chk("ce_cycle", 32'(cyc), 32'(expCyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCyc(input int target);
        while (cyc < target) step();
    endtask

    task automatic doReset();
        run_req  = 1'b0;
        step_req = 1'b0;
        nrst     = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int m;
        nrst = 1'b0; clk_sel = 2'b00; step_req = 1'b0; run_req = 1'b0;
        bp_en = 1'b0; bp_addr = 12'h000;
        step(); step(); step();
        nrst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle_halted", 32'(halted), 1);
            chk("idle_ce", 32'(cpu_ce), 0);
            chk("idle_bp_hit", 32'(bp_hit), 0);
            chk("idle_count", 32'(ce_count), 0);
        end

        // Step mode
        for (int i = 0; i < 3; i++) begin
            step_req = 1'b1;
            expQ.push_back(cyc + 1);
            step();
            step_req = 1'b0;
            repeat (4) step();
        end
        step();
        chk("step_count", 32'(ce_count), 3);
        chk("step_pending", 32'(expQ.size()), 0);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("step_run_ignored", 32'(halted), 1);
        step();
        chk("step_run_ignored2", 32'(halted), 1);

        // Full-speed run
        doReset();
        clk_sel = 2'b11;
        step(); step();
        n = cyc;
        run_req = 1'b1;
        for (int k = 0; k < 20; k++) expQ.push_back(n + 2 + k);
        step();
        run_req = 1'b0;
        chk("run_start_halted", 32'(halted), 0);
        waitCyc(n + 21);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("run_stop_halted", 32'(halted), 1);
        chk("run_stop_ce", 32'(cpu_ce), 0);
        step(); step();
        chk("run_count", 32'(ce_count), 20);
        chk("run_pending", 32'(expQ.size()), 0);

        // Slow run, then switch to medium in a tick cycle
        doReset();
        clk_sel = 2'b01;
        step(); step();
        n = cyc;
        run_req = 1'b1;
        expQ.push_back(n + 11); expQ.push_back(n + 21); expQ.push_back(n + 31);
        expQ.push_back(n + 45); expQ.push_back(n + 49); expQ.push_back(n + 53);
        step();
        run_req = 1'b0;
        waitCyc(n + 40);
        clk_sel = 2'b10;
        step();
        waitCyc(n + 54);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("div_stop_halted", 32'(halted), 1);
        step();
        chk("div_count", 32'(ce_count), 6);
        chk("div_pending", 32'(expQ.size()), 0);

        // Breakpoint at 0x005 and resume through it
        doReset();
        clk_sel = 2'b11; bp_en = 1'b1; bp_addr = 12'h005; pcTrack = 1'b1;
        step(); step();
        n = cyc;
        run_req = 1'b1;
        for (int k = 0; k < 5; k++) expQ.push_back(n + 2 + k);
        step();
        run_req = 1'b0;
        waitCyc(n + 7);
        chk("bp_halted", 32'(halted), 1);
        chk("bp_hit_set", 32'(bp_hit), 1);
        chk("bp_count", 32'(ce_count), 5);
        step();
        chk("bp_hit_sticky", 32'(bp_hit), 1);
        m = cyc;
        run_req = 1'b1;
        for (int k = 0; k < 10; k++) expQ.push_back(m + 2 + k);
        step();
        run_req = 1'b0;
        chk("resume_bp_clear", 32'(bp_hit), 0);
        chk("resume_halted", 32'(halted), 0);
        waitCyc(m + 11);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        step();
        chk("resume_count", 32'(ce_count), 15);
        chk("resume_pending", 32'(expQ.size()), 0);
        bp_en = 1'b0; pcTrack = 1'b0;

        // Counter wrap after 65536 pulses
        doReset();
        clk_sel = 2'b11;
        step(); step();
        n = cyc;
        run_req = 1'b1;
        for (int k = 0; k < 65536; k++) expQ.push_back(n + 2 + k);
        step();
        run_req = 1'b0;
        waitCyc(n + 65537);
        chk("wrap_pre", 32'(ce_count), 32'h0000_FFFF);
        run_req = 1'b1;
        step();
        run_req = 1'b0;
        chk("wrap_halted", 32'(halted), 1);
        chk("wrap_count", 32'(ce_count), 0);
        chk("wrap_pending", 32'(expQ.size()), 0);

        // run_req and step_req together: run wins, no step pulse
        n = cyc;
        run_req = 1'b1; step_req = 1'b1;
        for (int k = 0; k < 4; k++) expQ.push_back(n + 2 + k);
        step();
        run_req = 1'b0; step_req = 1'b0;
        chk("simul_halted", 32'(halted), 0);

        // Asynchronous reset in mid-run, checked before the next clock edge
        waitCyc(n + 6);
        chk("pre_reset_count", 32'(ce_count), 4);
        chk("pre_reset_ce", 32'(cpu_ce), 1);
        #1;
        nrst = 1'b0;
        #1;
        chk("async_halted", 32'(halted), 1);
        chk("async_ce", 32'(cpu_ce), 0);
        chk("async_bp_hit", 32'(bp_hit), 0);
        chk("async_count", 32'(ce_count), 0);
        step();
        nrst = 1'b1;
        repeat (3) step();
        chk("final_pending", 32'(expQ.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
